// File: rtl/mdu_pkg.sv
// -----------------------------------------------------------------------------
// mdu_pkg
// Shared definitions for the iterative multiply/divide unit.
//   state_t    : sequencer states (IDLE, MULT_RUN, DIV_RUN, FINISH)
//   OP_MULT/DIV: encoding of the op_div input
//   MDU_WIDTH  : default operand width
// -----------------------------------------------------------------------------
package mdu_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      MULT_RUN = 2'd1,
      DIV_RUN  = 2'd2,
      FINISH   = 2'd3
   } state_t;

   localparam logic OP_MULT   = 1'b0;
   localparam logic OP_DIV    = 1'b1;
   localparam int   MDU_WIDTH = 32;

endpackage

// File: rtl/mdu_div_step.sv
// -----------------------------------------------------------------------------
// mdu_div_step
// One combinational restoring-division step on unsigned magnitudes.
// Ports:
//   rem_in  [W-1:0] : partial remainder before this step (always < divisor)
//   dvd_msb         : next dividend bit shifted into the remainder
//   divisor [W-1:0] : divisor magnitude (non-zero)
//   rem_out [W:0]   : partial remainder after the step (top bit is always 0)
//   q_bit           : quotient bit produced by this step
// -----------------------------------------------------------------------------
module mdu_div_step
   import mdu_pkg::*;
#(
   parameter int WIDTH = MDU_WIDTH
) (
   input  logic [WIDTH-1:0] rem_in,
   input  logic             dvd_msb,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH:0]   rem_out,
   output logic             q_bit
);

   logic [WIDTH:0]   shifted;
   logic [WIDTH+1:0] diff;

   // The shifted remainder can reach 2*divisor-1, so it needs W+1 bits;
   // one more bit on the difference exposes the borrow.
   assign shifted = {rem_in, dvd_msb};
   assign diff    = {1'b0, shifted} - {2'b00, divisor};
   assign q_bit   = ~diff[WIDTH+1];
   assign rem_out = q_bit ? diff[WIDTH:0] : shifted;

endmodule

// File: rtl/mult_div_seq.sv
// -----------------------------------------------------------------------------
// mult_div_seq
// Iterative signed multiply / divide unit with its own sequencer. A start
// pulse in IDLE launches a WIDTH-step Booth multiply or restoring divide;
// a FINISH cycle then produces a one-cycle done pulse and HI/LO write strobe.
// Ports:
//   clock, reset      : clock, synchronous active-high reset
//   start             : request pulse, sampled only in IDLE
//   op_div            : 0 = MULT, 1 = DIV (sampled with start)
//   op_unsigned       : 1 = MULTU/DIVU (only with MDU_UNSIGNED_EN defined)
//   op_a, op_b        : rs / rt operands (sampled with start)
//   busy              : high from the cycle after acceptance until done
//   done              : one-cycle completion pulse
//   hi_lo_write       : HI/LO write strobe with done, suppressed on div by zero
//   hi_out, lo_out    : MULT product high/low, DIV remainder/quotient
//   div_zero          : one-cycle pulse with done when a DIV has op_b == 0
// Optional feature macro: MDU_UNSIGNED_EN (adds op_unsigned).
// -----------------------------------------------------------------------------
module mult_div_seq
   import mdu_pkg::*;
#(
   parameter int WIDTH = MDU_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             op_div,
`ifdef MDU_UNSIGNED_EN
   input  logic             op_unsigned,
`endif
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             busy,
   output logic             done,
   output logic             hi_lo_write,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out,
   output logic             div_zero
);

   localparam int ITER  = WIDTH;
   localparam int CNT_W = $clog2(ITER + 1);

   state_t                  state;
   logic [CNT_W-1:0]        iter_cnt;
   logic                    op_is_div;
   logic                    zero_div;

   // Shared datapath: {acc_hi, acc_lo, acc_qm1} is the Booth register pair
   // for MULT; for DIV acc_hi is the partial remainder and acc_lo shifts the
   // dividend out while the quotient shifts in. mcand holds M or the divisor.
   logic signed [WIDTH:0]   acc_hi;
   logic [WIDTH-1:0]        acc_lo;
   logic                    acc_qm1;
   logic signed [WIDTH:0]   mcand;
   logic                    is_unsigned;
   logic                    sign_a;
   logic                    sign_b;

   logic                    req_uns;
   logic                    a_neg;
   logic                    b_neg;
   logic [WIDTH-1:0]        a_mag;
   logic [WIDTH-1:0]        b_mag;
   logic signed [WIDTH:0]   booth_sum;
   logic                    shift_in;
   logic [WIDTH:0]          div_rem_nxt;
   logic                    div_q_bit;

`ifdef MDU_UNSIGNED_EN
   assign req_uns = op_unsigned;
`else
   assign req_uns = 1'b0;
`endif

   function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v,
                                                   input logic             neg);
      return neg ? (~v + 1'b1) : v;
   endfunction

   assign a_neg = ~req_uns & op_a[WIDTH-1];
   assign b_neg = ~req_uns & op_b[WIDTH-1];
   assign a_mag = apply_sign(op_a, a_neg);
   assign b_mag = apply_sign(op_b, b_neg);

   // Booth recoding on {Q[0], q_-1}; unsigned mode is plain shift-add on Q[0].
   // acc_hi carries one guard bit so that subtracting the most negative
   // multiplicand cannot overflow.
   always_comb begin
      booth_sum = acc_hi;
      if (is_unsigned) begin
         if (acc_lo[0]) booth_sum = acc_hi + mcand;
      end else begin
         case ({acc_lo[0], acc_qm1})
            2'b01:   booth_sum = acc_hi + mcand;
            2'b10:   booth_sum = acc_hi - mcand;
            default: booth_sum = acc_hi;
         endcase
      end
   end

   assign shift_in = is_unsigned ? 1'b0 : booth_sum[WIDTH];

   mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
      .rem_in  (acc_hi[WIDTH-1:0]),
      .dvd_msb (acc_lo[WIDTH-1]),
      .divisor (mcand[WIDTH-1:0]),
      .rem_out (div_rem_nxt),
      .q_bit   (div_q_bit)
   );

   // Operand capture and one iteration step per cycle
   always_ff @(posedge clock) begin
      case (state)
         IDLE: begin
            if (start) begin
               is_unsigned <= req_uns;
               sign_a      <= a_neg;
               sign_b      <= b_neg;
               acc_hi      <= '0;
               acc_qm1     <= 1'b0;
               if (op_div == OP_DIV) begin
                  acc_lo <= a_mag;
                  mcand  <= {1'b0, b_mag};
               end else begin
                  acc_lo <= op_b;
                  mcand  <= {~req_uns & op_a[WIDTH-1], op_a};
               end
            end
         end
         MULT_RUN: begin
            acc_hi  <= {shift_in, booth_sum[WIDTH:1]};
            acc_lo  <= {booth_sum[0], acc_lo[WIDTH-1:1]};
            acc_qm1 <= acc_lo[0];
         end
         DIV_RUN: begin
            acc_hi <= div_rem_nxt;
            acc_lo <= {acc_lo[WIDTH-2:0], div_q_bit};
         end
         default: ;
      endcase
   end

   // Sequencer with registered status outputs and HI/LO result registers
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         iter_cnt    <= '0;
         op_is_div   <= 1'b0;
         zero_div    <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         hi_lo_write <= 1'b0;
         div_zero    <= 1'b0;
         hi_out      <= '0;
         lo_out      <= '0;
      end else begin
         done        <= 1'b0;
         hi_lo_write <= 1'b0;
         div_zero    <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  iter_cnt  <= '0;
                  op_is_div <= op_div;
                  zero_div  <= (op_div == OP_DIV) && (op_b == '0);
                  busy      <= 1'b1;
                  if (op_div == OP_MULT)  state <= MULT_RUN;
                  else if (op_b != '0)    state <= DIV_RUN;
                  else                    state <= FINISH;
               end
            end
            MULT_RUN, DIV_RUN: begin
               iter_cnt <= iter_cnt + 1'b1;
               if (iter_cnt == CNT_W'(ITER - 1)) state <= FINISH;
            end
            FINISH: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b1;
               if (zero_div) begin
                  div_zero <= 1'b1;
               end else begin
                  hi_lo_write <= 1'b1;
                  if (op_is_div) begin
                     // Quotient sign follows the operand signs; remainder
                     // follows the dividend. Unsigned ops have both signs 0.
                     lo_out <= apply_sign(acc_lo, sign_a ^ sign_b);
                     hi_out <= apply_sign(acc_hi[WIDTH-1:0], sign_a);
                  end else begin
                     hi_out <= acc_hi[WIDTH-1:0];
                     lo_out <= acc_lo;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_div_seq.sv
module tb_mult_div_seq;

   localparam int W   = 32;
   localparam int LAT = W + 1;

   logic          clock  = 1'b0;
   logic          reset  = 1'b1;
   logic          start  = 1'b0;
   logic          op_div = 1'b0;
   logic [W-1:0]  op_a   = '0;
   logic [W-1:0]  op_b   = '0;
`ifdef MDU_UNSIGNED_EN
   logic          op_unsigned = 1'b0;
`endif
   logic          busy, done, hi_lo_write, div_zero;
   logic [W-1:0]  hi_out, lo_out;

   int n_pass  = 0;
   int n_total = 0;

   mult_div_seq #(.WIDTH(W)) dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .op_div      (op_div),
`ifdef MDU_UNSIGNED_EN
      .op_unsigned (op_unsigned),
`endif
      .op_a        (op_a),
      .op_b        (op_b),
      .busy        (busy),
      .done        (done),
      .hi_lo_write (hi_lo_write),
      .hi_out      (hi_out),
      .lo_out      (lo_out),
      .div_zero    (div_zero)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        d;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
   } vec_t;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
   } res_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      else
         n_pass++;
   endtask

   // Reference: MIPS-style results from plain 64-bit arithmetic.
   function automatic res_t model(input logic d, input logic u,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] prev_hi, input logic [31:0] prev_lo);
      res_t        r;
      longint      sa, sb, p, q, m;
      logic [63:0] up;
      r.hi = prev_hi;
      r.lo = prev_lo;
      r.dz = 1'b0;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (!d) begin
         if (u) up = {32'd0, a} * {32'd0, b};
         else begin
            p  = sa * sb;
            up = p;
         end
         r.hi = up[63:32];
         r.lo = up[31:0];
      end else if (b == 32'd0) begin
         r.dz = 1'b1;
      end else if (u) begin
         r.lo = a / b;
         r.hi = a % b;
      end else begin
         q = sa / sb;
         m = sa % sb;
         r.lo = q[31:0];
         r.hi = m[31:0];
      end
      return r;
   endfunction

   // Launch one operation and wait (bounded) for done; also samples the
   // cycle after done to confirm the pulse width.
   task automatic run_op(input logic d, input logic u, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic hlw, output logic dz,
                         output logic [31:0] hi, output logic [31:0] lo,
                         output logic busy_ok, output logic done_after);
      @(negedge clock);
      start  = 1'b1;
      op_div = d;
      op_a   = a;
      op_b   = b;
`ifdef MDU_UNSIGNED_EN
      op_unsigned = u;
`else
      if (u) $display("note: unsigned request ignored in signed-only build");
`endif
      @(posedge clock);
      #1 start = 1'b0;
      lat = 0;
      busy_ok = 1'b1;
      forever begin
         @(posedge clock);
         #1 lat++;
         if (done || lat >= 100) break;
         if (!busy) busy_ok = 1'b0;
      end
      hlw = hi_lo_write;
      dz  = div_zero;
      hi  = hi_out;
      lo  = lo_out;
      @(posedge clock);
      #1 done_after = done;
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0:       return 32'h8000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h0;
         3:       return 32'($urandom_range(0, 20));
         default: return 32'($urandom);
      endcase
   endfunction

   initial begin
      vec_t        vecs[8];
      int          lat;
      logic        hlw, dz, bok, dafter, d, u;
      logic [31:0] hi, lo, a, b, prev_hi, prev_lo;
      res_t        exp_r;
      int          n_done, first_done;
      logic [31:0] cap_hi, cap_lo;

      vecs[0] = '{1'b0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
      vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
      vecs[2] = '{1'b1, 32'd5,          32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1};
      vecs[3] = '{1'b0, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 32'h0,         1'b0};
      vecs[4] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 1'b0};
      vecs[5] = '{1'b1, 32'd100,        32'd7,         32'd2,         32'd14,        1'b0};
      vecs[6] = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0,         32'd1,         1'b0};
      vecs[7] = '{1'b1, 32'd7,          32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};

      // Reset state
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_hlw",  hi_lo_write, 0);
      chk("rst_dz",   div_zero, 0);
      chk("rst_hi",   hi_out, 0);
      chk("rst_lo",   lo_out, 0);

      // Directed table
      for (int i = 0; i < 8; i++) begin
         run_op(vecs[i].d, 1'b0, vecs[i].a, vecs[i].b, lat, hlw, dz, hi, lo, bok, dafter);
         chk($sformatf("vec%0d_lat", i),  lat, vecs[i].dz ? 1 : LAT);
         chk($sformatf("vec%0d_hlw", i),  hlw, !vecs[i].dz);
         chk($sformatf("vec%0d_dz", i),   dz,  vecs[i].dz);
         chk($sformatf("vec%0d_hi", i),   hi,  vecs[i].hi);
         chk($sformatf("vec%0d_lo", i),   lo,  vecs[i].lo);
         chk($sformatf("vec%0d_busy", i), bok, 1);
         chk($sformatf("vec%0d_pulse", i), dafter, 0);
      end

      // Second start during a MULT is ignored
      @(negedge clock);
      start = 1'b1; op_div = 1'b0; op_a = 32'd1234; op_b = 32'd5678;
      @(posedge clock);
      #1 start = 1'b0;
      n_done = 0; first_done = -1; cap_hi = '0; cap_lo = '0;
      for (int c = 1; c <= 45; c++) begin
         @(posedge clock);
         #1;
         if (c == 10) begin
            start = 1'b1; op_a = 32'd3; op_b = 32'd3;
         end
         if (c == 11) start = 1'b0;
         if (done) begin
            n_done++;
            if (first_done < 0) begin
               first_done = c; cap_hi = hi_out; cap_lo = lo_out;
            end
         end
      end
      chk("ign_ndone", n_done, 1);
      chk("ign_lat",   first_done, LAT);
      chk("ign_hi",    cap_hi, 32'd0);
      chk("ign_lo",    cap_lo, 32'd7006652);

      // Reset in the middle of a DIV
      @(negedge clock);
      start = 1'b1; op_div = 1'b1; op_a = 32'd1000; op_b = 32'd3;
      @(posedge clock);
      #1 start = 1'b0;
      repeat (15) @(posedge clock);
      #1 reset = 1'b1;
      @(posedge clock);
      #1 reset = 1'b0;
      chk("mrst_busy", busy, 0);
      chk("mrst_done", done, 0);
      chk("mrst_hi",   hi_out, 0);
      chk("mrst_lo",   lo_out, 0);
      n_done = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clock);
         #1 if (done) n_done++;
      end
      chk("mrst_nodone", n_done, 0);
      run_op(1'b1, 1'b0, 32'd100, 32'd7, lat, hlw, dz, hi, lo, bok, dafter);
      chk("post_lat", lat, LAT);
      chk("post_lo",  lo, 32'd14);
      chk("post_hi",  hi, 32'd2);

      // Randomized against the reference model
      prev_hi = 32'd2;
      prev_lo = 32'd14;
      for (int i = 0; i < 40; i++) begin
         d = 1'($urandom_range(0, 1));
`ifdef MDU_UNSIGNED_EN
         u = 1'($urandom_range(0, 1));
`else
         u = 1'b0;
`endif
         a = pick();
         b = pick();
         if (d && $urandom_range(0, 7) == 0) b = 32'd0;
         exp_r = model(d, u, a, b, prev_hi, prev_lo);
         run_op(d, u, a, b, lat, hlw, dz, hi, lo, bok, dafter);
         chk($sformatf("rnd%0d_lat", i), lat, exp_r.dz ? 1 : LAT);
         chk($sformatf("rnd%0d_hlw", i), hlw, !exp_r.dz);
         chk($sformatf("rnd%0d_dz", i),  dz,  exp_r.dz);
         chk($sformatf("rnd%0d_hi", i),  hi,  exp_r.hi);
         chk($sformatf("rnd%0d_lo", i),  lo,  exp_r.lo);
         prev_hi = exp_r.hi;
         prev_lo = exp_r.lo;
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/mult_div_seq.md
Name: mult_div_seq

Overview:
- Iterative signed multiply/divide unit plus its own sequencer, serving MULT and DIV for the multicycle control FSM.
- The control FSM pulses `start` once and waits for `done`.
- The block then presents HI/LO results with a one-cycle write strobe to the HI/LO registers.
- Replaces the counter-in-controller approach; the control FSM only waits on `busy`/`done`.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- ITER, WIDTH, iteration count of the run states; fixed equal to WIDTH.

Ports:
- clock  input  1  system clock, all state changes on rising edge
- reset  input  1  synchronous, active-high; one clock, reset is synchronous and active-high
- start  input  1  request pulse; sampled only in IDLE
- op_div  input  1  0 = MULT, 1 = DIV; sampled with start
- op_a  input  WIDTH  rs operand (multiplicand / dividend); sampled with start
- op_b  input  WIDTH  rt operand (multiplier / divisor); sampled with start
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle completion pulse
- hi_lo_write  output  1  one-cycle HI/LO write strobe, coincident with done, except on divide-by-zero
- hi_out  output  WIDTH  MULT: product[2W-1:W]; DIV: remainder
- lo_out  output  WIDTH  MULT: product[W-1:0]; DIV: quotient
- div_zero  output  1  one-cycle pulse with done when DIV has op_b == 0

Behaviour:
- Reset values:
  - state = IDLE; busy = 0, done = 0, hi_lo_write = 0, div_zero = 0.
  - hi_out = 0, lo_out = 0; iteration counter = 0.
- Reset mid-operation aborts immediately to IDLE with the same values. No partial write.
- States: IDLE, MULT_RUN, DIV_RUN, FINISH.
- IDLE:
  - start = 1: latch op_a, op_b, op_div and clear the counter.
  - If op_div = 0, go to MULT_RUN.
  - If op_div = 1 and op_b != 0, go to DIV_RUN.
  - If op_div = 1 and op_b == 0, go to FINISH with the zero flag set.
- start while busy is ignored; there is no queueing.
- MULT_RUN:
  - Radix-2 Booth step on the {A, Q, q_-1} register pair, one step per cycle.
  - Arithmetic right shift of (2W+1) bits.
  - Counter increments; after ITER steps, go to FINISH.
- DIV_RUN:
  - Restoring division on magnitudes |op_a|, |op_b|, one quotient bit per cycle; ITER steps, then FINISH.
  - Partial remainder is held in W+1 bits to avoid carry loss.
- FINISH (exactly one cycle):
  - Apply signs: quotient negated iff sign(op_a) XOR sign(op_b); remainder takes sign(op_a).
  - Assert done = 1. Assert hi_lo_write = 1 unless divide-by-zero.
  - Load hi_out/lo_out, then return to IDLE.
- Divide by zero: div_zero = 1, done = 1, hi_lo_write = 0; hi_out/lo_out hold their previous values.
- Latency:
  - start accepted at edge N; busy high during cycles N+1 .. N+ITER+1; done at cycle N+ITER+1 (33 cycles at default).
  - Divide-by-zero: done at N+1.
- hi_out/lo_out hold their value until the next FINISH.
- Wrap rules:
  - DIV of 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0 (two's-complement wrap, no flag).
  - MULT of 0x80000000 * 0x80000000: HI = 0x40000000, LO = 0.
- done and start on the same cycle: the new start is accepted only once the block is back in IDLE (next cycle).

Optional Feature:
- Macro MDU_UNSIGNED_EN.
- Defined:
  - Adds input `op_unsigned` (1 bit), sampled with start.
  - When op_unsigned = 1 (MULTU/DIVU): no sign handling; MULT uses a shift-add on a (2W+1)-bit accumulator; DIV uses raw operands; FINISH applies no sign fixup.
  - Latency is unchanged.
- Undefined: the port is absent and all operations are signed.

Decomposition:
- Shared package mdu_pkg:
  - state enum: IDLE, MULT_RUN, DIV_RUN, FINISH.
  - op encoding constants: OP_MULT = 0, OP_DIV = 1.
  - MDU_WIDTH = 32.
- One sub-module: mdu_div_step.
  - Combinational restoring step: trial subtract, select, quotient bit.
- The Booth step stays inline in mult_div_seq.

Test Plan:
- MULT 7 * -3 → done at cycle 33; hi_lo_write = 1; HI = 0xFFFFFFFF, LO = 0xFFFFFFEB.
- DIV -7 / 2 → LO = 0xFFFFFFFD (-3), HI = 0xFFFFFFFF (-1), div_zero = 0.
- DIV 5 / 0 → done and div_zero at cycle 1; hi_lo_write = 0; HI/LO unchanged from the prior result.
- MULT 0x80000000 * 0x80000000 → HI = 0x40000000, LO = 0; DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- Second start pulsed at cycle 10 of a MULT → ignored; a single done at cycle 33 with the first operands' result.
- reset asserted at cycle 15 of a DIV → next cycle IDLE, busy = 0, hi_out = lo_out = 0, no done; a new DIV 100 / 7 then gives LO = 14, HI = 2.
